// File: rtl/vma_diag_reader.sv
// Diagnostic EBUS master for the VMA board. Walks select codes 0..7 through
// DIAG 04-06 with DIAG READ FUNC 15X asserted, samples the seven odd EBUS
// lines D11..D23 after a settle delay, and assembles the captured fields
// into VMA and VMA HELD/PC words (bits 13..35). Both words are committed together
// only once the full readout has completed.
module vma_diag_reader #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk_h,
    input  logic        reset_h,
    input  logic        start_h,
    input  logic        abort_h,
    output logic        busy_h,
    output logic        done_h,
    output logic        diag_04_b_h,
    output logic        diag_05_b_h,
    output logic        diag_06_b_h,
    output logic        diag_read_func_15x_l,
    input  logic        ebus_d11_e_h,
    input  logic        ebus_d13_e_h,
    input  logic        ebus_d15_e_h,
    input  logic        ebus_d17_e_h,
    input  logic        ebus_d19_e_h,
    input  logic        ebus_d21_e_h,
    input  logic        ebus_d23_e_h,
    output logic [22:0] vma_h,
    output logic [22:0] held_pc_h
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CAPTURE,
        GAP,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  sel;
    logic [3:0]  settle_cnt;
    logic [22:0] vma_sh;
    logic [22:0] held_sh;
    logic [6:0]  sample;

    // d11 is the most significant bit of each returned field
    assign sample = {ebus_d11_e_h, ebus_d13_e_h, ebus_d15_e_h, ebus_d17_e_h,
                     ebus_d19_e_h, ebus_d21_e_h, ebus_d23_e_h};

    assign diag_04_b_h = sel[2];
    assign diag_05_b_h = sel[1];
    assign diag_06_b_h = sel[0];

    // State register
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state handshake/strobe outputs
    always_comb begin
        state_nxt            = state;
        busy_h               = 1'b1;
        done_h               = 1'b0;
        diag_read_func_15x_l = 1'b1;
        case (state)
            IDLE: begin
                busy_h = 1'b0;
                if (start_h) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                diag_read_func_15x_l = 1'b0;
                state_nxt            = SETTLE;
            end
            SETTLE: begin
                diag_read_func_15x_l = 1'b0;
                if (settle_cnt == 4'd0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                diag_read_func_15x_l = 1'b0;
                state_nxt            = (sel == 3'd7) ? DONE : GAP;
            end
            GAP: begin
                state_nxt = DRIVE;
            end
            DONE: begin
                done_h    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort_h) begin
            state_nxt = IDLE;
        end
    end

    // Select sequencing, settle timing, field capture and final commit
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            sel        <= '0;
            settle_cnt <= '0;
            vma_sh     <= '0;
            held_sh    <= '0;
            vma_h      <= '0;
            held_pc_h  <= '0;
        end else if (abort_h) begin
            sel <= '0;
        end else begin
            case (state)
                DRIVE: begin
                    settle_cnt <= 4'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    if (sel[2]) begin
                        case (sel[1:0])
                            2'd0:    held_sh[22:16] <= sample;
                            2'd1:    held_sh[15:9]  <= sample;
                            2'd2:    held_sh[8:2]   <= sample;
                            default: held_sh[1:0]   <= sample[6:5];
                        endcase
                    end else begin
                        case (sel[1:0])
                            2'd0:    vma_sh[22:16] <= sample;
                            2'd1:    vma_sh[15:9]  <= sample;
                            2'd2:    vma_sh[8:2]   <= sample;
                            default: vma_sh[1:0]   <= sample[6:5];
                        endcase
                    end
                    // Commit on the last capture so the outputs are already
                    // updated while done_h is high in DONE; the final HELD/PC
                    // bits are taken straight from the bus.
                    if (sel == 3'd7) begin
                        vma_h     <= vma_sh;
                        held_pc_h <= {held_sh[22:2], sample[6:5]};
                    end
                end
                GAP: begin
                    sel <= sel + 3'd1;
                end
                DONE: begin
                    sel <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vma_diag_reader.sv
// Testbench for vma_diag_reader: behavioural VMA board model per instance,
// scoreboard of expected words, protocol monitor for SETTLE_CYCLES 1/2/15.
module tb_vma_diag_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic [22:0] model_vma  = '0;
    logic [22:0] model_held = '0;
    logic        junk       = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [45:0] exp_q[$];

    // Board model: returns the 7-bit field for a select code
    function automatic logic [6:0] board(input logic [22:0] v, input logic [22:0] h,
                                         input logic [2:0] s, input logic j);
        logic [22:0] w;
        w = s[2] ? h : v;
        case (s[1:0])
            2'd0:    board = w[22:16];
            2'd1:    board = w[15:9];
            2'd2:    board = w[8:2];
            default: board = {w[1:0], {5{j}}};
        endcase
    endfunction

    // Three instances: index 0 = SETTLE 2 (main), 1 = SETTLE 1, 2 = SETTLE 15
    logic [2:0]  busy_v, done_v, stb_v;
    logic [2:0]  sel_v [3];
    logic [6:0]  bus_v [3];
    logic [22:0] vma_v [3];
    logic [22:0] held_v[3];
    int unsigned settle_v[3] = '{2, 1, 15};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic s4, s5, s6;
        assign sel_v[g] = {s4, s5, s6};
        assign bus_v[g] = board(model_vma, model_held, {s4, s5, s6}, junk);
        vma_diag_reader #(
            .SETTLE_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)
        ) u_dut (
            .clk_h               (clk),
            .reset_h             (reset),
            .start_h             (start),
            .abort_h             (abort),
            .busy_h              (busy_v[g]),
            .done_h              (done_v[g]),
            .diag_04_b_h         (s4),
            .diag_05_b_h         (s5),
            .diag_06_b_h         (s6),
            .diag_read_func_15x_l(stb_v[g]),
            .ebus_d11_e_h        (bus_v[g][6]),
            .ebus_d13_e_h        (bus_v[g][5]),
            .ebus_d15_e_h        (bus_v[g][4]),
            .ebus_d17_e_h        (bus_v[g][3]),
            .ebus_d19_e_h        (bus_v[g][2]),
            .ebus_d21_e_h        (bus_v[g][1]),
            .ebus_d23_e_h        (bus_v[g][0]),
            .vma_h               (vma_v[g]),
            .held_pc_h           (held_v[g])
        );
    end

    // Protocol monitor: strobe-low windows, their length and select stability
    logic       mon_en = 1'b0;
    logic [2:0] prev_stb = '1;
    int         win_cnt[3], bad_len[3], bad_sel[3], win_len[3];
    logic [2:0] win_sel[3];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (!stb_v[i]) begin
                    if (prev_stb[i]) begin
                        win_len[i] = 1;
                        win_sel[i] = sel_v[i];
                    end else begin
                        win_len[i] = win_len[i] + 1;
                        if (sel_v[i] != win_sel[i]) bad_sel[i] = bad_sel[i] + 1;
                    end
                end else if (!prev_stb[i]) begin
                    win_cnt[i] = win_cnt[i] + 1;
                    if (win_len[i] != int'(settle_v[i] + 2)) bad_len[i] = bad_len[i] + 1;
                end
            end
            prev_stb = stb_v;
        end
    end

    // Waits for done on the main instance; reports cycles since start was sampled
    task automatic wait_done(input int limit, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < limit && !seen) begin
            @(negedge clk);
            n++;
            if (done_v[0]) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || stb_v[0] !== 1'b1 || sel_v[0] !== 3'd0 ||
            vma_v[0] !== 23'd0 || held_v[0] !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b stb=%b sel=%0d vma=%h held=%h, want 0 0 1 0 0 0",
                     busy_v[0], done_v[0], stb_v[0], sel_v[0], vma_v[0], held_v[0]);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_readout(input logic [22:0] v, input logic [22:0] h, input logic j,
                                input string name);
        int n;
        bit seen;
        logic [45:0] e;
        model_vma = v;
        model_held = h;
        junk = j;
        exp_q.push_back({v, h});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        seen = done_v[0];
        if (!seen) begin
            wait_done(200, n, seen);
            n++;
        end
        tests_run++;
        if (!seen || n != 40) begin
            tests_failed++;
            $display("FAIL %s_latency: done seen=%0b at cycle %0d, want cycle 40", name, seen, n);
        end
        if (seen) begin
            tests_run++;
            e = exp_q.pop_front();
            if ({vma_v[0], held_v[0]} !== e) begin
                tests_failed++;
                $display("FAIL %s_data: vma=%h held=%h, want vma=%h held=%h",
                         name, vma_v[0], held_v[0], e[45:23], e[22:0]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_after: done=%b busy=%b, want 0 0", name, done_v[0], busy_v[0]);
        end
    endtask

    task automatic test_abort;
        bit got_done;
        model_vma = 23'h0F0F0F;
        model_held = 23'h707070;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // negedge 1 is DRIVE of sel0; CAPTURE of sel3 is cycle 3*5+4 = 19
        repeat (18) @(negedge clk);
        tests_run++;
        if (sel_v[0] !== 3'd3 || stb_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_setup: sel=%0d stb=%b, want 3 0", sel_v[0], stb_v[0]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy_v[0] !== 1'b0 || stb_v[0] !== 1'b1 || sel_v[0] !== 3'd0 || done_v[0] !== 1'b0 ||
            vma_v[0] !== 23'h2A5A5A || held_v[0] !== 23'h15A5A5) begin
            tests_failed++;
            $display("FAIL abort_idle: busy=%b stb=%b sel=%0d done=%b vma=%h held=%h, want 0 1 0 0 2a5a5a 15a5a5",
                     busy_v[0], stb_v[0], sel_v[0], done_v[0], vma_v[0], held_v[0]);
        end
        got_done = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) got_done = 1'b1;
        end
        tests_run++;
        if (got_done !== 1'b0 || vma_v[0] !== 23'h2A5A5A) begin
            tests_failed++;
            $display("FAIL abort_quiet: activity=%b vma=%h, want 0 2a5a5a", got_done, vma_v[0]);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit seen;
        logic [45:0] e;
        model_vma = 23'h3C3C3C;
        model_held = 23'h0A0A0B;
        junk = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({model_vma, model_held});
            wait_done(200, n, seen);
            tests_run++;
            if (!seen || n != ((k == 0) ? 40 : 41)) begin
                tests_failed++;
                $display("FAIL b2b_interval%0d: done seen=%0b after %0d cycles, want %0d",
                         k, seen, n, (k == 0) ? 40 : 41);
            end
            if (seen) begin
                tests_run++;
                e = exp_q.pop_front();
                if ({vma_v[0], held_v[0]} !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_data%0d: vma=%h held=%h, want vma=%h held=%h",
                             k, vma_v[0], held_v[0], e[45:23], e[22:0]);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy_v[0] !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_stop: busy=%b queue=%0d, want 0 0", busy_v[0], exp_q.size());
        end
    endtask

    task automatic test_protocol;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            win_cnt[i] = 0;
            bad_len[i] = 0;
            bad_sel[i] = 0;
            win_len[i] = 0;
        end
        prev_stb = '1;
        mon_en = 1'b1;
        model_vma = 23'h55AA33;
        model_held = 23'h2BCDEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8 * 17 + 12) @(negedge clk);
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (win_cnt[i] != 8 || bad_len[i] != 0 || bad_sel[i] != 0 || busy_v[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL protocol_settle%0d: windows=%0d badlen=%0d badsel=%0d busy=%b, want 8 0 0 0",
                         settle_v[i], win_cnt[i], bad_len[i], bad_sel[i], busy_v[i]);
            end
            tests_run++;
            if (vma_v[i] !== 23'h55AA33 || held_v[i] !== 23'h2BCDEF) begin
                tests_failed++;
                $display("FAIL protocol_data%0d: vma=%h held=%h, want 55aa33 2bcdef",
                         settle_v[i], vma_v[i], held_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // sel5 DRIVE at cycle 26, SETTLE at 27-28
        repeat (26) @(negedge clk);
        tests_run++;
        if (sel_v[0] !== 3'd5 || stb_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_setup: sel=%0d stb=%b busy=%b, want 5 0 1",
                     sel_v[0], stb_v[0], busy_v[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy_v[0] !== 1'b0 || stb_v[0] !== 1'b1 || sel_v[0] !== 3'd0 ||
            vma_v[0] !== 23'd0 || held_v[0] !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b stb=%b sel=%0d vma=%h held=%h, want 0 1 0 0 0",
                     busy_v[0], stb_v[0], sel_v[0], vma_v[0], held_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_readout(23'h2A5A5A, 23'h15A5A5, 1'b0, "readout");
        test_abort();
        test_readout(23'h7FFFFC, 23'h123458, 1'b1, "unused_lines");
        test_back_to_back();
        test_protocol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
